// File: rtl/simon_btn_debounce.sv
// simon_btn_debounce
//
// This block conditions the simon push-buttons before they reach the game core.
// Each raw pin is synchronised into the clock domain and then debounced. A button
// changes level only after it has stayed at the new value for DEBOUNCE_MS
// consecutive milliseconds. The millisecond timebase comes from ticks_per_milli,
// which is the same value the core uses.
//
// The core receives clean levels and one-cycle press/release events. A press event
// is reported only for a lone button, so a chord never counts as several presses.
//
// Ports:
//   clk             system clock, single domain
//   rst             synchronous, active-high reset
//   ticks_per_milli clk cycles per millisecond (quasi-static; 0 or 1 = every cycle)
//   btn_raw         raw asynchronous active-high button pins
//   btn_level       debounced button levels (registered)
//   btn_press       one-cycle press event, lone button only (registered)
//   btn_release     one-cycle release event (registered)
//   any_pressed     OR of btn_level
//   milli_tick      one-cycle pulse per millisecond (registered)

module simon_btn_debounce #(
  parameter int NUM_BTN     = 4,
  parameter int DEBOUNCE_MS = 10,
  parameter int TICKS_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [TICKS_W-1:0] ticks_per_milli,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic               any_pressed,
  output logic               milli_tick
);

  localparam int CNT_W = (DEBOUNCE_MS < 1) ? 1 : $clog2(DEBOUNCE_MS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MS - 1);

  logic [TICKS_W-1:0] pc;
  logic               pc_wrap;

  logic [NUM_BTN-1:0] sync_meta;
  logic [NUM_BTN-1:0] sync;

  logic [CNT_W-1:0]   cnt      [NUM_BTN];
  logic [CNT_W-1:0]   cnt_next [NUM_BTN];
  logic [NUM_BTN-1:0] level_next;
  logic [NUM_BTN-1:0] press_next;
  logic [NUM_BTN-1:0] release_next;

  // The comparison is pc+1 >= ticks_per_milli, done one bit wider. This form is
  // equivalent to pc >= ticks_per_milli-1 but cannot underflow when
  // ticks_per_milli is 0, so settings of 0 and 1 both tick on every cycle.
  assign pc_wrap = ({1'b0, pc} + {{TICKS_W{1'b0}}, 1'b1}) >= {1'b0, ticks_per_milli};

  // Millisecond prescaler. Because the test is ">=", a runtime decrease of
  // ticks_per_milli below the current count wraps and ticks on the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= '0;
      milli_tick <= 1'b0;
    end else begin
      milli_tick <= pc_wrap;
      pc         <= pc_wrap ? '0 : pc + TICKS_W'(1);
    end
  end

  // Two-flop synchroniser for the asynchronous pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync      <= sync_meta;
    end
  end

  // Debounce qualification, independent for each button. Any cycle in which
  // the synchronised pin agrees with the current level restarts the count, so
  // only an uninterrupted run of DEBOUNCE_MS ticks flips the level.
  // Press events are reported only for a lone button: the previous levels must
  // be all-zero and the new levels exactly one-hot at that bit. This suppresses
  // both kinds of chord: a press while another button is held, and simultaneous
  // presses.
  always_comb begin
    level_next = btn_level;
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_next[i] = cnt[i];
      if (sync[i] == btn_level[i]) begin
        cnt_next[i] = '0;
      end else if (milli_tick) begin
        if (cnt[i] == CNT_LAST) begin
          level_next[i] = ~btn_level[i];
          cnt_next[i]   = '0;
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end

    release_next = btn_level & ~level_next;
    press_next   = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      press_next[i] = (btn_level == '0) && (level_next == (NUM_BTN'(1) << i));
    end
  end

  // Level, event and counter registers. The events are registered together with
  // the level, so each event appears in the same cycle as the level change.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_level   <= '0;
      btn_press   <= '0;
      btn_release <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      btn_level   <= level_next;
      btn_press   <= press_next;
      btn_release <= release_next;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

  assign any_pressed = |btn_level;

endmodule

// File: tb/tb_simon_btn_debounce.sv
// tb_simon_btn_debounce
//
// Directed bench for simon_btn_debounce with DEBOUNCE_MS=10 and, unless
// changed, ticks_per_milli=16.
//
// Inputs are driven 1 time unit after a rising edge, and outputs are sampled at
// that same point.
//
// From reset release with a button already asserted, the level rises on the
// 161st edge:
//   - 2 edges fill the synchroniser;
//   - ticks are acted on at edges 17, 33, ..., 161.
// A press that starts at an arbitrary phase lands in 146..162 edges.

module tb_simon_btn_debounce;

  logic       clk;
  logic       rst;
  logic [7:0] ticks_per_milli;
  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_release;
  logic       any_pressed;
  logic       milli_tick;

  int checks;
  int errors;

  simon_btn_debounce #(
    .NUM_BTN(4),
    .DEBOUNCE_MS(10),
    .TICKS_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ticks_per_milli(ticks_per_milli),
    .btn_raw(btn_raw),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_release(btn_release),
    .any_pressed(any_pressed),
    .milli_tick(milli_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Single-cycle synchronous reset. Inputs set here take effect from the first
  // non-reset edge onward.
  task automatic applyStimulus(input logic [3:0] raw);
    rst = 1'b1;
    step(1);
    rst     = 1'b0;
    btn_raw = raw;
  endtask

  // Counts the edges until btn_level differs from its value at call time.
  // Returns -1 if the bound expires.
  task automatic wait_change(input int bound, output int n);
    logic [3:0] start;
    start = btn_level;
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      step(1);
      if (btn_level !== start) begin
        n = i;
        break;
      end
    end
  endtask

  // Counts the edges until milli_tick is next seen high. Returns -1 if the
  // bound expires.
  task automatic wait_tick(input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      step(1);
      if (milli_tick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    int cnt;
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    ticks_per_milli = 8'd16;
    btn_raw         = 4'b0000;
    step(3);

    checkOutput("reset_level", btn_level, 4'b0000);
    checkOutput("reset_press", btn_press, 4'b0000);
    checkOutput("reset_release", btn_release, 4'b0000);
    checkOutput("reset_any", any_pressed, 1'b0);
    checkOutput("reset_tick", milli_tick, 1'b0);

    // Prescaler: first tick after reset, regular spacing, every-cycle mode,
    // and a runtime decrease while pc=10.
    rst = 1'b0;
    wait_tick(40, n);
    checkOutput("tick_first", n, 16);
    wait_tick(40, n);
    checkOutput("tick_spacing16", n, 16);
    ticks_per_milli = 8'd0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (milli_tick) cnt++;
    end
    checkOutput("tick_every_cycle", cnt, 5);
    ticks_per_milli = 8'd16;
    step(10);
    ticks_per_milli = 8'd4;
    step(1);
    checkOutput("tick_after_decrease", milli_tick, 1'b1);
    wait_tick(20, n);
    checkOutput("tick_spacing4", n, 4);
    ticks_per_milli = 8'd16;

    // Clean press of button 2 starting at reset release, then release 50 ms later.
    applyStimulus(4'b0100);
    wait_change(400, n);
    checkOutput("clean_press_latency", n, 161);
    checkOutput("clean_level", btn_level, 4'b0100);
    checkOutput("clean_press", btn_press, 4'b0100);
    checkOutput("clean_any", any_pressed, 1'b1);
    step(1);
    checkOutput("clean_press_one_cycle", btn_press, 4'b0000);
    step(800);
    btn_raw = 4'b0000;
    wait_change(400, n);
    checkOutput("clean_release_window", (n >= 146 && n <= 162), 1'b1);
    checkOutput("clean_release", btn_release, 4'b0100);
    checkOutput("clean_release_press", btn_press, 4'b0000);
    checkOutput("clean_release_any", any_pressed, 1'b0);
    step(1);
    checkOutput("clean_release_one_cycle", btn_release, 4'b0000);

    // Bounce on button 0: 20 phases of 40 clk each, then a stable high.
    applyStimulus(4'b0000);
    cnt = 0;
    for (int s = 0; s < 20; s++) begin
      btn_raw[0] = ~s[0];
      for (int k = 0; k < 40; k++) begin
        step(1);
        if (btn_level !== 4'b0000 || btn_press !== 4'b0000) cnt++;
      end
    end
    checkOutput("bounce_quiet", cnt, 0);
    btn_raw = 4'b0001;
    wait_change(400, n);
    checkOutput("bounce_latency_window", (n >= 146 && n <= 162), 1'b1);
    checkOutput("bounce_press", btn_press, 4'b0001);
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      step(1);
      if (btn_press !== 4'b0000) cnt++;
    end
    checkOutput("bounce_single_press", cnt, 0);

    // Chord: button 1 held first, then button 3 pressed, released and re-pressed.
    applyStimulus(4'b0010);
    wait_change(400, n);
    checkOutput("chord_first_press", btn_press, 4'b0010);
    btn_raw = 4'b1010;
    wait_change(400, n);
    checkOutput("chord_level", btn_level, 4'b1010);
    checkOutput("chord_no_press", btn_press, 4'b0000);
    btn_raw = 4'b0010;
    wait_change(400, n);
    checkOutput("chord_release_level", btn_level, 4'b0010);
    checkOutput("chord_release", btn_release, 4'b1000);
    btn_raw = 4'b1010;
    wait_change(400, n);
    checkOutput("chord_repress_level", btn_level, 4'b1010);
    checkOutput("chord_repress_no_press", btn_press, 4'b0000);

    // Simultaneous press and release of buttons 0 and 1.
    applyStimulus(4'b0011);
    wait_change(400, n);
    checkOutput("simul_level", btn_level, 4'b0011);
    checkOutput("simul_no_press", btn_press, 4'b0000);
    btn_raw = 4'b0000;
    wait_change(400, n);
    checkOutput("simul_release_level", btn_level, 4'b0000);
    checkOutput("simul_release", btn_release, 4'b0011);

    // Reset in the middle of qualification discards the 5 ms already accumulated.
    applyStimulus(4'b0100);
    step(80);
    rst = 1'b1;
    step(1);
    checkOutput("midreset_level", btn_level, 4'b0000);
    checkOutput("midreset_press", btn_press, 4'b0000);
    checkOutput("midreset_tick", milli_tick, 1'b0);
    rst = 1'b0;
    wait_change(400, n);
    checkOutput("midreset_latency", n, 161);
    checkOutput("midreset_press_after", btn_press, 4'b0100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simon_btn_debounce.md
Name: simon_btn_debounce

Overview:
Input-conditioning stage directly upstream of the simon game core. It takes the four raw, asynchronous, bouncy push-button pins and synchronises and debounces them. The millisecond timebase is derived from the same ticks_per_milli value the core uses. The core receives clean button levels plus single-cycle press and release events, so it never sees bounce or chords as multiple presses.

Parameters:
NUM_BTN, 4, number of buttons
DEBOUNCE_MS, 10, milliseconds an input must remain stable before the debounced level changes; legal range 1..255
TICKS_W, 8, width of ticks_per_milli

Ports:
clk  input  1  system clock, single clock domain
rst  input  1  synchronous, active-high reset
ticks_per_milli  input  TICKS_W  clk cycles per millisecond; quasi-static
btn_raw  input  NUM_BTN  raw button pins, asynchronous, active-high
btn_level  output  NUM_BTN  debounced button levels, registered
btn_press  output  NUM_BTN  one-cycle press event, registered
btn_release  output  NUM_BTN  one-cycle release event, registered
any_pressed  output  1  OR of btn_level
milli_tick  output  1  one-cycle pulse per millisecond, registered

Behaviour:
- Reset: synchronous on rst=1.
  - All outputs are 0.
  - Synchroniser flops, prescaler and per-button counters are cleared.
  - Reset mid-debounce discards all accumulated stability time.
- Prescaler:
  - Counter pc counts 0..ticks_per_milli-1.
  - When pc >= ticks_per_milli-1, milli_tick=1 for the following cycle and pc wraps to 0.
  - Using >= handles a runtime decrease of ticks_per_milli: the next cycle ticks and wraps.
  - ticks_per_milli of 0 or 1 produces milli_tick every cycle.
  - First milli_tick after reset release: ticks_per_milli cycles later.
- Synchroniser:
  - 2-flop chain per bit, producing sync[i].
  - Latency from btn_raw to sync is 2 clk.
- Per-button debounce, independent per i:
  - Counter cnt[i] has width ceil(log2(DEBOUNCE_MS+1)).
  - If sync[i] == btn_level[i]: cnt[i] <= 0.
  - Else, on a milli_tick cycle: if cnt[i] == DEBOUNCE_MS-1, btn_level[i] toggles and cnt[i] <= 0; otherwise cnt[i]++.
  - Else, on a non-tick cycle: cnt[i] holds.
  - Any glitch back to the current level restarts qualification from 0.
  - Latency from a clean raw edge to btn_level: 2 clk + (DEBOUNCE_MS-1 to DEBOUNCE_MS) ms, quantised to milli_tick.
- Events are registered and assert in the same cycle btn_level first shows the new value:
  - btn_release[i] pulses on every 1->0 transition of btn_level[i], unconditionally.
  - btn_press[i] pulses on a 0->1 transition only if the previous btn_level was all-zero and the new btn_level is exactly one-hot at bit i.
  - Chord suppression, case 1: a press that qualifies while another button is held produces no press event.
  - Chord suppression, case 2: presses that qualify in the same cycle on two or more buttons produce no press event for any of them.
  - A button released and re-pressed produces a new press event only once the new press qualifies.
- At most one btn_press bit is ever set in a cycle.
- Event outputs never assert two consecutive cycles for the same bit.
- any_pressed = |btn_level, combinational from registers, no extra latency.

Test Plan:
All scenarios use DEBOUNCE_MS=10 and ticks_per_milli=16 unless stated.
1. Prescaler: ticks_per_milli=16 -> milli_tick spacing exactly 16 clk. Switch to 0 -> milli_tick high every cycle. Switch 16->4 while pc=10 -> tick on the next cycle, then every 4 clk.
2. Clean press: btn_raw=4'b0100 held from cycle T. btn_level becomes 4'b0100 within [T+2+144, T+2+160]. btn_press=4'b0100 for exactly 1 cycle, simultaneous with the btn_level rise. any_pressed=1. Release after 50 ms -> btn_release=4'b0100 for 1 cycle after the same delay.
3. Bounce: btn_raw[0] toggles every 40 clk for 800 clk, then holds 1 -> no btn_level or btn_press change during bounce. Exactly one btn_press=4'b0001, 10 ms (±1 ms) after the final edge.
4. Chord: btn 1 held and qualified, then btn 3 pressed -> btn_level=4'b1010, btn_press stays 0. Release btn 3 -> btn_release=4'b1000. Re-press btn 3 -> still no press, since btn 1 is held.
5. Simultaneous: btn_raw 4'b0000 -> 4'b0011 in one cycle -> btn_level=4'b0011 in one cycle with btn_press=0. Release both -> btn_release=4'b0011 in one cycle.
6. Reset mid-operation: btn 2 held 5 ms, rst pulsed 1 cycle -> all outputs 0 the next cycle. With btn held throughout, btn_press=4'b0100 occurs 2 clk + 10 ms after rst deasserts, not 5 ms.
